llki_discrete_master: RTL
=========================

Name: llki_discrete_master

Overview:
- Initiator end of the LLKI discrete key-load channel. Drives the four-phase req/ack handshake that an LLKI discrete slave inside a core wrapper responds to.
- Accepts one command at a time from the host/key-manager side (load key, clear key, query status).
- A load command is sent as KEY_WORDS 64-bit word transfers. Each command ends with a single-cycle response carrying the completion status.

Parameters:
- KEY_WORDS, 2, number of 64-bit key words per LOAD (1..16)
- IDX_W, 4, width of the word-index field (2**IDX_W >= KEY_WORDS)
- TIMEOUT_CYCLES, 1024, maximum cycles waited for any ack edge (>= 2)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  master idle and able to accept a command
- cmd_op  in  2  0=LOAD, 1=CLEAR, 2=STATUS, 3=reserved (treated as STATUS)
- cmd_key  in  64*KEY_WORDS  key; word i = cmd_key[64*i+63:64*i]; captured on accept
- rsp_valid  out  1  one-cycle response strobe
- rsp_status  out  2  0=OK, 1=SLAVE_ERR, 2=TIMEOUT
- rsp_loaded  out  1  slave key-loaded flag, sampled at the last ack rise
- llki_req  out  1  transfer request
- llki_op  out  2  opcode of the current transfer
- llki_widx  out  IDX_W  word index of the current transfer
- llki_data  out  64  key word (0 for CLEAR/STATUS)
- llki_ack  in  1  slave acknowledge
- llki_err  in  1  slave error, valid when llki_ack rises
- llki_loaded  in  1  slave key-loaded, valid when llki_ack rises

Behaviour:
- All outputs are registered. While rst_n=0 at a clk edge, all outputs go to 0, the FSM goes to IDLE, and the captured key and counters clear. A reset mid-transfer drops llki_req immediately and issues no response.
- FSM states: IDLE, REQ, REL, DRAIN, RESP.
- IDLE:
  - cmd_ready=1 only if llki_ack=0.
  - Accept on cmd_valid & cmd_ready: capture op and key, set widx=0, err_flag=0, go to REQ.
  - llki_req=1 in the cycle after accept.
- REQ:
  - llki_req=1; llki_op, llki_widx and llki_data are stable for the whole state.
  - On llki_ack=1: sample llki_err and llki_loaded, go to REL (llki_req=0 next cycle).
- REL:
  - llki_req=0; wait for llki_ack=0.
  - Then, if err_flag, or the op is not LOAD, or widx==KEY_WORDS-1: go to RESP.
  - Otherwise increment widx and go to REQ.
- Error handling: a sampled llki_err sets err_flag and ends the command after the current handshake completes. Remaining words are not sent.
- Timeout:
  - A wait counter clears on every entry to REQ or REL and increments each cycle the awaited ack level is absent.
  - On reaching TIMEOUT_CYCLES: set status TIMEOUT, drop llki_req, go to DRAIN.
- DRAIN: llki_req=0; wait without limit for llki_ack=0, then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_status: TIMEOUT takes priority over SLAVE_ERR, which takes priority over OK.
  - rsp_loaded = last sampled llki_loaded; it is 0 if no ack rise occurred.
  - Next state is IDLE. There is no response back-pressure.
- Minimum LOAD latency, from accept to rsp_valid, with an ack that answers in zero cycles: 2*KEY_WORDS+1 cycles.
- cmd_valid while busy is ignored (cmd_ready=0); the host holds the command.
- An ack already high in IDLE (slave stuck) blocks acceptance until it falls.

Test Plan:
- LOAD, key words {0xA5A5..., 0x0123_4567_89AB_CDEF}, slave acks after 1 cycle with loaded=1 -> two handshakes, widx 0 then 1, data matches each word, rsp_status=0, rsp_loaded=1.
- CLEAR with a zero-delay slave -> one handshake with llki_op=1, llki_data=0, rsp_valid 3 cycles after accept, rsp_status=0.
- LOAD with KEY_WORDS=2, slave asserts err on word 0 -> no word-1 request, rsp_status=1.
- Slave never acks, TIMEOUT_CYCLES=16 -> llki_req drops after 16 cycles of REQ, rsp_status=2, then cmd_ready=1.
- Slave holds ack high for 40 cycles after a timeout -> DRAIN holds, cmd_ready=0 until ack falls, rsp_status=2.
- rst_n=0 during word 1 of a LOAD -> llki_req=0 and rsp_valid=0 the next cycle; a new LOAD after reset starts at widx=0.

Source files
------------

// File: rtl/llki_discrete_master.sv
// Initiator end of the LLKI discrete key-load channel: accepts one host command,
// runs the four-phase req/ack handshake per key word and returns a one-cycle status.
module llki_discrete_master #(
    parameter int KEY_WORDS      = 2,
    parameter int IDX_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [64*KEY_WORDS-1:0] cmd_key,
    output logic                    rsp_valid,
    output logic [1:0]              rsp_status,
    output logic                    rsp_loaded,
    output logic                    llki_req,
    output logic [1:0]              llki_op,
    output logic [IDX_W-1:0]        llki_widx,
    output logic [63:0]             llki_data,
    input  logic                    llki_ack,
    input  logic                    llki_err,
    input  logic                    llki_loaded
);
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(KEY_WORDS - 1);
    localparam logic [1:0]        OP_LOAD   = 2'd0;
    localparam logic [1:0]        OP_STATUS = 2'd2;
    localparam logic [1:0]        ST_OK        = 2'd0;
    localparam logic [1:0]        ST_SLAVE_ERR = 2'd1;
    localparam logic [1:0]        ST_TIMEOUT   = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_REL, S_DRAIN, S_RESP} state_t;

    state_t                  r_state;
    logic [64*KEY_WORDS-1:0] r_key;
    logic [CNT_W-1:0]        r_wait_cnt;
    logic                    r_err_flag;
    logic                    r_timeout;
    logic                    r_loaded;
    logic                    r_cmd_ready;
    logic                    r_rsp_valid;
    logic [1:0]              r_rsp_status;
    logic                    r_rsp_loaded;
    logic                    r_llki_req;
    logic [1:0]              r_llki_op;
    logic [IDX_W-1:0]        r_llki_widx;
    logic [63:0]             r_llki_data;

    logic                    w_accept;
    logic [1:0]              w_op_norm;
    logic [64*KEY_WORDS-1:0] w_key_shift;
    logic                    w_wait_expired;
    logic                    w_last_word;

    assign w_accept       = r_cmd_ready & cmd_valid;
    assign w_op_norm      = (cmd_op == 2'd3) ? OP_STATUS : cmd_op;
    // Remaining key words sit in r_key; word 0 is always the next one to send.
    assign w_key_shift    = r_key >> 64;
    assign w_wait_expired = (r_wait_cnt == CNT_LAST);
    assign w_last_word    = r_err_flag || (r_llki_op != OP_LOAD) || (r_llki_widx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_key        <= '0;
            r_wait_cnt   <= '0;
            r_err_flag   <= 1'b0;
            r_timeout    <= 1'b0;
            r_loaded     <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= ST_OK;
            r_rsp_loaded <= 1'b0;
            r_llki_req   <= 1'b0;
            r_llki_op    <= '0;
            r_llki_widx  <= '0;
            r_llki_data  <= '0;
        end else begin
            r_rsp_valid  <= 1'b0;
            r_rsp_status <= ST_OK;
            r_rsp_loaded <= 1'b0;
            r_cmd_ready  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_key       <= cmd_key;
                        r_llki_op   <= w_op_norm;
                        r_llki_widx <= '0;
                        r_llki_data <= (w_op_norm == OP_LOAD) ? cmd_key[63:0] : 64'd0;
                        r_err_flag  <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_loaded    <= 1'b0;
                        r_wait_cnt  <= '0;
                        r_llki_req  <= 1'b1;
                        r_state     <= S_REQ;
                    end else begin
                        // A stuck-high ack from the slave keeps the host out.
                        r_cmd_ready <= ~llki_ack;
                    end
                end
                S_REQ: begin
                    if (llki_ack) begin
                        r_err_flag <= llki_err;
                        r_loaded   <= llki_loaded;
                        r_llki_req <= 1'b0;
                        r_wait_cnt <= '0;
                        r_state    <= S_REL;
                    end else if (w_wait_expired) begin
                        r_timeout  <= 1'b1;
                        r_llki_req <= 1'b0;
                        r_state    <= S_DRAIN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_REL: begin
                    if (!llki_ack) begin
                        if (w_last_word) begin
                            r_state <= S_RESP;
                        end else begin
                            r_llki_widx <= r_llki_widx + 1'b1;
                            r_key       <= w_key_shift;
                            r_llki_data <= w_key_shift[63:0];
                            r_wait_cnt  <= '0;
                            r_llki_req  <= 1'b1;
                            r_state     <= S_REQ;
                        end
                    end else if (w_wait_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!llki_ack) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_status <= r_timeout ? ST_TIMEOUT : (r_err_flag ? ST_SLAVE_ERR : ST_OK);
                    r_rsp_loaded <= r_loaded;
                    r_cmd_ready  <= ~llki_ack;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_status = r_rsp_status;
    assign rsp_loaded = r_rsp_loaded;
    assign llki_req   = r_llki_req;
    assign llki_op    = r_llki_op;
    assign llki_widx  = r_llki_widx;
    assign llki_data  = r_llki_data;

endmodule
